// File: rtl/otter_mem_responder.sv
// OTTER memory responder: dual-port word RAM plus timer/soft-interrupt MMIO.
// Define OTTER_MEM_ERR_EN to raise o_err and drop faulting writes.
module otter_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] MMIO_BASE   = 32'h1100_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_imem_addr,
  output logic [31:0] o_imem_r_data,
  input  logic        i_dmem_re,
  input  logic        i_dmem_we,
  input  logic [3:0]  i_dmem_sel,
  input  logic [31:0] i_dmem_addr,
  input  logic [31:0] i_dmem_w_data,
  output logic [31:0] o_dmem_r_data,
  output logic [31:0] o_intrpt,
  output logic        o_err
);

  localparam int unsigned AW  = $clog2(DEPTH_WORDS);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] irdata_q, irdata_d;
  logic [31:0] drdata_q, drdata_d;
  logic        msip_q, msip_d;
  logic        tip_q, tip_d;
  logic        err_q, err_d;

  logic          i_ram_hit;
  logic [AW-1:0] i_idx;
  logic          d_ram_hit;
  logic          d_mmio_hit;
  logic [AW-1:0] d_idx;
  logic [31:0]   d_off;
  logic [2:0]    m_idx;
  logic          fault;
  logic          wr_ok;
  logic          wr_ram;
  logic [31:0]   mmio_rd;
  logic [31:0]   d_rd;
  logic          unused_addr;

  assign i_ram_hit  = (i_imem_addr[31:AW+2] == '0);
  assign i_idx      = i_imem_addr[AW+1:2];
  assign d_ram_hit  = (i_dmem_addr[31:AW+2] == '0);
  assign d_idx      = i_dmem_addr[AW+1:2];
  assign d_off      = i_dmem_addr - MMIO_BASE;
  assign d_mmio_hit = (d_off < 32'h18);
  assign m_idx      = d_off[4:2];

  assign unused_addr = ^{i_imem_addr[1:0], i_dmem_addr[1:0]};

`ifdef OTTER_MEM_ERR_EN
  logic sel_ok;

  always_comb begin
    sel_ok = 1'b0;
    unique case (i_dmem_addr[1:0])
      2'b00: sel_ok = (i_dmem_sel == 4'b0001) ||
                      (i_dmem_sel == 4'b0011) ||
                      (i_dmem_sel == 4'b1111);
      2'b01: sel_ok = (i_dmem_sel == 4'b0010);
      2'b10: sel_ok = (i_dmem_sel == 4'b0100) ||
                      (i_dmem_sel == 4'b1100);
      default: sel_ok = (i_dmem_sel == 4'b1000);
    endcase
  end

  assign fault = (i_dmem_re | i_dmem_we) &
                 (~(d_ram_hit | d_mmio_hit) | ~sel_ok);
`else
  assign fault = 1'b0;
`endif

  assign wr_ok  = i_dmem_we & ~i_rst & ~fault;
  assign wr_ram = wr_ok & d_ram_hit;

  always_comb begin
    mmio_rd = '0;
    case (m_idx)
      3'd0:    mmio_rd = mtime_q[31:0];
      3'd1:    mmio_rd = shadow_q;
      3'd2:    mmio_rd = mtimecmp_q[31:0];
      3'd3:    mmio_rd = mtimecmp_q[63:32];
      3'd4:    mmio_rd = {31'b0, msip_q};
      default: mmio_rd = '0;
    endcase
  end

  always_comb begin
    d_rd = '0;
    unique case (1'b1)
      d_ram_hit:  d_rd = mem_q[d_idx];
      d_mmio_hit: d_rd = mmio_rd;
      default:    d_rd = '0;
    endcase
  end

  always_comb begin
    mtime_d    = mtime_q + 64'd1;
    mtimecmp_d = mtimecmp_q;
    shadow_d   = shadow_q;
    msip_d     = msip_q;
    tip_d      = (mtime_q >= mtimecmp_q);
    err_d      = fault;
    irdata_d   = i_ram_hit ? mem_q[i_idx] : NOP;
    drdata_d   = i_dmem_re ? d_rd : drdata_q;
    if (i_dmem_re && d_mmio_hit && m_idx == 3'd0)
      shadow_d = mtime_q[63:32];
    if (wr_ok && d_mmio_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (i_dmem_sel[b] && m_idx == 3'd2)
          mtimecmp_d[8*b +: 8] = i_dmem_w_data[8*b +: 8];
        if (i_dmem_sel[b] && m_idx == 3'd3)
          mtimecmp_d[32+8*b +: 8] = i_dmem_w_data[8*b +: 8];
      end
      if (m_idx == 3'd4 && i_dmem_sel[0])
        msip_d = i_dmem_w_data[0];
      // Acknowledge is applied last so it wins over a same-cycle set.
      if (m_idx == 3'd5 && i_dmem_sel[0] && i_dmem_w_data[0])
        msip_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_ram) begin
      for (int b = 0; b < 4; b++) begin
        if (i_dmem_sel[b])
          mem_q[d_idx][8*b +: 8] <= i_dmem_w_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      shadow_q   <= '0;
      msip_q     <= 1'b0;
      tip_q      <= 1'b0;
      err_q      <= 1'b0;
      irdata_q   <= NOP;
      drdata_q   <= '0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      shadow_q   <= shadow_d;
      msip_q     <= msip_d;
      tip_q      <= tip_d;
      err_q      <= err_d;
      irdata_q   <= irdata_d;
      drdata_q   <= drdata_d;
    end
  end

  assign o_imem_r_data = irdata_q;
  assign o_dmem_r_data = drdata_q;
  assign o_intrpt      = {24'b0, tip_q, 3'b0, msip_q, 3'b0};
  assign o_err         = err_q;

endmodule

// File: tb/tb_otter_mem_responder.sv
// Directed self-checking bench for otter_mem_responder.
// Build with OTTER_MEM_ERR_EN defined to exercise the fault path.
module tb_otter_mem_responder;

  localparam logic [31:0] BASE = 32'h1100_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        re;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] daddr;
  logic [31:0] wdata;
  logic [31:0] drdata;
  logic [31:0] intrpt;
  logic        err;

  int checks = 0;
  int fails  = 0;

  otter_mem_responder dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_imem_addr   (imem_addr),
    .o_imem_r_data (imem_rdata),
    .i_dmem_re     (re),
    .i_dmem_we     (we),
    .i_dmem_sel    (sel),
    .i_dmem_addr   (daddr),
    .i_dmem_w_data (wdata),
    .o_dmem_r_data (drdata),
    .o_intrpt      (intrpt),
    .o_err         (err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d,
                    input logic [3:0] s);
    re = 1'b0; we = 1'b1; daddr = a; wdata = d; sel = s;
    cyc();
    we = 1'b0; sel = 4'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    re = 1'b1; we = 1'b0; daddr = a; sel = 4'hF;
    cyc();
    re = 1'b0; sel = 4'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; re = 1'b0; we = 1'b0; sel = 4'b0;
    daddr = '0; wdata = '0; imem_addr = 32'h40;
    cyc(); cyc();
    checks++;
    if (imem_rdata !== NOP) begin
      fails++; $display("FAIL reset_imem got %h want %h", imem_rdata, NOP);
    end
    checks++;
    if (drdata !== 32'h0) begin
      fails++; $display("FAIL reset_drdata got %h want 0", drdata);
    end
    checks++;
    if (intrpt !== 32'h0) begin
      fails++; $display("FAIL reset_intrpt got %h want 0", intrpt);
    end
    checks++;
    if (err !== 1'b0) begin
      fails++; $display("FAIL reset_err got %b want 0", err);
    end
    rst = 1'b0; imem_addr = 32'h8000_0000;
  endtask

  task automatic test_ram_rw();
    wr(32'h40, 32'hDEAD_BEEF, 4'hF);
    rd(32'h40);
    checks++;
    if (drdata !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL ram_rw got %h want DEADBEEF", drdata);
    end
  endtask

  task automatic test_read_first();
    re = 1'b1; we = 1'b1; daddr = 32'h40;
    wdata = 32'h0000_5500; sel = 4'b0010;
    cyc();
    re = 1'b0; we = 1'b0; sel = 4'b0;
    checks++;
    if (drdata !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL read_first got %h want DEADBEEF", drdata);
    end
    rd(32'h40);
    checks++;
    if (drdata !== 32'hDEAD_55EF) begin
      fails++; $display("FAIL byte_lane got %h want DEAD55EF", drdata);
    end
    daddr = 32'h2000_0000;
    cyc();
    checks++;
    if (drdata !== 32'hDEAD_55EF) begin
      fails++; $display("FAIL hold got %h want DEAD55EF", drdata);
    end
    wr(32'h40, 32'h0, 4'b0000);
    rd(32'h43);
    checks++;
    if (drdata !== 32'hDEAD_55EF) begin
      fails++; $display("FAIL sel0_noop got %h want DEAD55EF", drdata);
    end
  endtask

  task automatic test_imem();
    imem_addr = 32'h40;
    cyc();
    checks++;
    if (imem_rdata !== 32'hDEAD_55EF) begin
      fails++; $display("FAIL imem_fetch got %h want DEAD55EF", imem_rdata);
    end
    imem_addr = 32'h0000_4000;
    cyc();
    checks++;
    if (imem_rdata !== NOP) begin
      fails++; $display("FAIL imem_oob got %h want %h", imem_rdata, NOP);
    end
    imem_addr = 32'h40;
    wr(32'h40, 32'h1234_5678, 4'hF);
    checks++;
    if (imem_rdata !== 32'hDEAD_55EF) begin
      fails++; $display("FAIL imem_rf got %h want DEAD55EF", imem_rdata);
    end
    cyc();
    checks++;
    if (imem_rdata !== 32'h1234_5678) begin
      fails++; $display("FAIL imem_new got %h want 12345678", imem_rdata);
    end
    imem_addr = 32'h8000_0000;
  endtask

  task automatic test_unmapped();
    rd(32'h40);
    rd(BASE + 32'h18);
    checks++;
    if (drdata !== 32'h0) begin
      fails++; $display("FAIL unmapped_mmio got %h want 0", drdata);
    end
  endtask

  task automatic test_msip();
    wr(BASE + 32'h10, 32'hFFFF_FFFF, 4'hF);
    checks++;
    if (intrpt[3] !== 1'b1) begin
      fails++; $display("FAIL msip_set got %b want 1", intrpt[3]);
    end
    rd(BASE + 32'h10);
    checks++;
    if (drdata !== 32'h1) begin
      fails++; $display("FAIL msip_rd got %h want 1", drdata);
    end
    wr(BASE + 32'h14, 32'h1, 4'hF);
    checks++;
    if (intrpt[3] !== 1'b0) begin
      fails++; $display("FAIL irq_ack got %b want 0", intrpt[3]);
    end
    rd(BASE + 32'h14);
    checks++;
    if (drdata !== 32'h0) begin
      fails++; $display("FAIL ack_rd got %h want 0", drdata);
    end
  endtask

  task automatic test_mtime();
    force dut.mtime_q = 64'h0000_0001_FFFF_FFFF;
    #1;
    release dut.mtime_q;
    rd(BASE);
    checks++;
    if (drdata !== 32'hFFFF_FFFF) begin
      fails++; $display("FAIL mtime_lo got %h want FFFFFFFF", drdata);
    end
    rd(BASE + 32'h4);
    checks++;
    if (drdata !== 32'h1) begin
      fails++; $display("FAIL mtime_shadow got %h want 1", drdata);
    end
    force dut.mtime_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.mtime_q;
    cyc();
    checks++;
    if (dut.mtime_q !== 64'h0) begin
      fails++; $display("FAIL mtime_wrap got %h want 0", dut.mtime_q);
    end
  endtask

  task automatic test_timer_irq();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    wr(BASE + 32'hC, 32'h0, 4'hF);
    wr(BASE + 32'h8, 32'd20, 4'hF);
    for (int e = 3; e <= 24; e++) begin
      cyc();
      if (e == 20 || e == 21 || e == 24) begin
        checks++;
        if (intrpt !== ((e >= 21) ? 32'h80 : 32'h0)) begin
          fails++;
          $display("FAIL timer_irq edge %0d got %h want %h", e, intrpt,
                   (e >= 21) ? 32'h80 : 32'h0);
        end
      end
    end
    rd(BASE + 32'h8);
    checks++;
    if (drdata !== 32'd20) begin
      fails++; $display("FAIL cmp_lo got %h want 14", drdata);
    end
    wr(BASE + 32'hC, 32'hAABB_CCDD, 4'b0100);
    rd(BASE + 32'hC);
    checks++;
    if (drdata !== 32'h00BB_0000) begin
      fails++; $display("FAIL cmp_hi_lane got %h want 00BB0000", drdata);
    end
  endtask

  task automatic test_reset_mid();
    wr(BASE + 32'h10, 32'h1, 4'hF);
    rd(32'h40);
    checks++;
    if (drdata !== 32'h1234_5678) begin
      fails++; $display("FAIL ram_kept got %h want 12345678", drdata);
    end
    rst = 1'b1; re = 1'b1; sel = 4'hF;
    daddr = 32'h40; imem_addr = 32'h40;
    cyc();
    checks++;
    if ({drdata, imem_rdata, intrpt, 31'b0, err} !==
        {32'h0, NOP, 32'h0, 32'h0}) begin
      fails++;
      $display("FAIL reset_mid got %h %h %h %b want 0 %h 0 0",
               drdata, imem_rdata, intrpt, err, NOP);
    end
    re = 1'b0; we = 1'b1; wdata = 32'h0;
    cyc();
    rst = 1'b0; we = 1'b0; sel = 4'b0;
    imem_addr = 32'h8000_0000;
    rd(32'h40);
    checks++;
    if (drdata !== 32'h1234_5678) begin
      fails++; $display("FAIL rst_wr_drop got %h want 12345678", drdata);
    end
  endtask

  task automatic test_err();
`ifdef OTTER_MEM_ERR_EN
    rd(32'h2000_0000);
    checks++;
    if ({err, drdata} !== {1'b1, 32'h0}) begin
      fails++; $display("FAIL err_unmapped got %b %h want 1 0", err, drdata);
    end
    cyc();
    checks++;
    if (err !== 1'b0) begin
      fails++; $display("FAIL err_pulse got %b want 0", err);
    end
    wr(32'h41, 32'h0000_ABCD, 4'b0011);
    checks++;
    if (err !== 1'b1) begin
      fails++; $display("FAIL err_misalign got %b want 1", err);
    end
    rd(32'h40);
    checks++;
    if (drdata !== 32'h1234_5678) begin
      fails++; $display("FAIL err_drop got %h want 12345678", drdata);
    end
`else
    rd(32'h2000_0000);
    checks++;
    if ({err, drdata} !== {1'b0, 32'h0}) begin
      fails++; $display("FAIL unmapped got %b %h want 0 0", err, drdata);
    end
    wr(32'h41, 32'h0000_ABCD, 4'b0011);
    rd(32'h40);
    checks++;
    if (drdata !== 32'h1234_ABCD) begin
      fails++; $display("FAIL misalign_wr got %h want 1234ABCD", drdata);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_ram_rw();
    test_read_first();
    test_imem();
    test_unmapped();
    test_msip();
    test_mtime();
    test_timer_irq();
    test_reset_mid();
    test_err();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
